// File: rtl/ysyx_25060170_lsu_pipe.sv
// Load/store unit: handles one op at a time (IDLE -> REQ -> WAIT -> DONE).
// Optional misalign trap is enabled by defining YSYX_25060170_LSU_MISALIGN_EN.
module ysyx_25060170_lsu_pipe #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   alu_res,
  input  logic [DATA_W-1:0]   store_data,
  input  logic [3:0]          ls_ctl,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [2:0]          mem_size,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
`ifdef YSYX_25060170_LSU_MISALIGN_EN
  ,
  output logic                ls_except,
  output logic [3:0]          ls_cause
`endif
);
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state;

  logic             is_load, is_store, is_mem, illegal;
  logic [1:0]       acc_size;
  logic [OFF_W-1:0] off;
  logic [15:0]      strb_base;
  logic [15:0]      strb_shift;
  logic [DATA_W-1:0] byte_mask, wdata_n, load_val, rd_sh;
  logic [3:0]       op_r;
  logic [OFF_W-1:0] off_r;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    acc_size = 2'd0;
    case (ls_ctl)
      4'b1001, 4'b1101: begin is_load = 1'b1; acc_size = 2'd0; end
      4'b1010, 4'b1110: begin is_load = 1'b1; acc_size = 2'd1; end
      4'b1011, 4'b1111: begin is_load = 1'b1; acc_size = 2'd2; end
      4'b1100:          begin is_load = 1'b1; acc_size = 2'd3; end
      4'b0001:          begin is_store = 1'b1; acc_size = 2'd0; end
      4'b0010:          begin is_store = 1'b1; acc_size = 2'd1; end
      4'b0100:          begin is_store = 1'b1; acc_size = 2'd2; end
      4'b0101:          begin is_store = 1'b1; acc_size = 2'd3; end
      default: ;
    endcase
  end

  assign is_mem  = is_load | is_store;
  // Doubleword and lwu have no meaning on a 32-bit datapath.
  assign illegal = (DATA_W == 32) &&
                   (ls_ctl == 4'b1100 || ls_ctl == 4'b0101 || ls_ctl == 4'b1111);
  assign off     = alu_res[OFF_W-1:0];

  // Byte mask of the access width; lanes pushed past the word are dropped.
  assign strb_base  = (16'd1 << (5'd1 << acc_size)) - 16'd1;
  assign strb_shift = strb_base << off;

  for (genvar i = 0; i < STRB_W; i++) begin : g_bmask
    assign byte_mask[8*i +: 8] = {8{strb_base[i]}};
  end

  assign wdata_n = (store_data & byte_mask) << {off, 3'b000};

  assign rd_sh = mem_rdata >> {off_r, 3'b000};
  always_comb begin
    load_val = rd_sh;
    case (op_r)
      4'b1001: load_val = DATA_W'($signed(rd_sh[7:0]));
      4'b1010: load_val = DATA_W'($signed(rd_sh[15:0]));
      4'b1011: load_val = DATA_W'($signed(rd_sh[31:0]));
      4'b1101: load_val = DATA_W'(rd_sh[7:0]);
      4'b1110: load_val = DATA_W'(rd_sh[15:0]);
      4'b1111: load_val = DATA_W'(rd_sh[31:0]);
      default: load_val = rd_sh;
    endcase
  end

`ifdef YSYX_25060170_LSU_MISALIGN_EN
  logic              misaligned;
  logic [DATA_W-1:0] fault_addr;
  assign misaligned = |(alu_res[2:0] & ((3'd1 << acc_size) - 3'd1));
  assign fault_addr = DATA_W'(ADDR_W'(alu_res));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      out_data      <= '0;
      mem_req_valid <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_wstrb     <= '0;
      mem_size      <= '0;
      op_r          <= '0;
      off_r         <= '0;
`ifdef YSYX_25060170_LSU_MISALIGN_EN
      ls_except     <= 1'b0;
      ls_cause      <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          in_ready <= 1'b0;
          if (!is_mem) begin
            out_data  <= alu_res;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (illegal) begin
            out_data  <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
`ifdef YSYX_25060170_LSU_MISALIGN_EN
          else if (misaligned) begin
            out_data  <= fault_addr;
            out_valid <= 1'b1;
            ls_except <= 1'b1;
            ls_cause  <= is_load ? 4'd4 : 4'd6;
            state     <= DONE;
          end
`endif
          else begin
            mem_req_valid <= 1'b1;
            mem_we        <= is_store;
            mem_addr      <= ADDR_W'(alu_res);
            mem_wdata     <= is_store ? wdata_n : '0;
            mem_wstrb     <= is_store ? strb_shift[STRB_W-1:0] : '0;
            mem_size      <= {1'b0, acc_size};
            op_r          <= ls_ctl;
            off_r         <= off;
            state         <= REQ;
          end
        end
        REQ: if (mem_req_ready) begin
          mem_req_valid <= 1'b0;
          mem_we        <= 1'b0;
          mem_wdata     <= '0;
          mem_wstrb     <= '0;
          state         <= WAIT;
        end
        WAIT: if (mem_rsp_valid) begin
          out_data  <= op_r[3] ? load_val : '0;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
`ifdef YSYX_25060170_LSU_MISALIGN_EN
          ls_except <= 1'b0;
          ls_cause  <= '0;
`endif
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_25060170_lsu_pipe.sv
// Directed bench for ysyx_25060170_lsu_pipe (DATA_W=64): expected writeback
// values go through a scoreboard queue, bus fields are checked inline.
module tb_ysyx_25060170_lsu_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [63:0] alu_res, store_data;
  logic [3:0]  ls_ctl;
  logic        out_valid, out_ready;
  logic [63:0] out_data;
  logic        mem_req_valid, mem_req_ready, mem_we;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic [2:0]  mem_size;
  logic        mem_rsp_valid;
  logic [63:0] mem_rdata;
`ifdef YSYX_25060170_LSU_MISALIGN_EN
  logic        ls_except;
  logic [3:0]  ls_cause;
`endif

  ysyx_25060170_lsu_pipe #(.DATA_W(64), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_res(alu_res), .store_data(store_data), .ls_ctl(ls_ctl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_size(mem_size),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
`ifdef YSYX_25060170_LSU_MISALIGN_EN
    , .ls_except(ls_except), .ls_cause(ls_cause)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic        exc;
    logic [3:0]  cause;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One op end to end; inputs change and outputs are sampled at negedge.
  task automatic run_op(input string tag, input logic [3:0] ctl,
                        input logic [63:0] alu, input logic [63:0] sd,
                        input logic [63:0] rdata, input int req_lat, input int out_lat,
                        input bit exp_bus, input logic exp_we, input logic [7:0] exp_strb,
                        input logic [63:0] exp_wdata, input logic [2:0] exp_size,
                        input logic [63:0] exp_data, input logic exp_exc,
                        input logic [3:0] exp_cause);
    exp_t e;
    @(negedge clk);
    chk({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; ls_ctl = ctl; alu_res = alu; store_data = sd;
    sb.push_back('{data: exp_data, exc: exp_exc, cause: exp_cause});
    @(negedge clk);
    in_valid = 1'b0; alu_res = 64'hDEAD_DEAD_DEAD_DEAD; store_data = 64'hFEED_FEED_FEED_FEED;
    if (exp_bus) begin
      for (int i = 0; i <= req_lat; i++) begin
        chk({tag, ".req_valid"}, 64'(mem_req_valid), 64'd1);
        chk({tag, ".req_we"},    64'(mem_we),        64'(exp_we));
        chk({tag, ".req_addr"},  64'(mem_addr),      64'(alu[31:0]));
        chk({tag, ".req_wdata"}, mem_wdata,          exp_wdata);
        chk({tag, ".req_wstrb"}, 64'(mem_wstrb),     64'(exp_strb));
        chk({tag, ".req_size"},  64'(mem_size),      64'(exp_size));
        chk({tag, ".req_in_ready"}, 64'(in_ready),   64'd0);
        chk({tag, ".req_out_valid"}, 64'(out_valid), 64'd0);
        mem_rsp_valid = (i < req_lat);   // stray response while in REQ
        mem_req_ready = (i == req_lat);
        @(negedge clk);
      end
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      chk({tag, ".wait_req_valid"}, 64'(mem_req_valid), 64'd0);
      chk({tag, ".wait_out_valid"}, 64'(out_valid), 64'd0);
      @(negedge clk);
      chk({tag, ".wait2_out_valid"}, 64'(out_valid), 64'd0);
      mem_rsp_valid = 1'b1; mem_rdata = rdata;
      @(negedge clk);
      mem_rsp_valid = 1'b0; mem_rdata = 64'h5A5A_5A5A_5A5A_5A5A;
    end else begin
      chk({tag, ".no_req"}, 64'(mem_req_valid), 64'd0);
    end
    for (int i = 0; i <= out_lat; i++) begin
      chk({tag, ".out_valid"}, 64'(out_valid), 64'd1);
      chk({tag, ".done_in_ready"}, 64'(in_ready), 64'd0);
      chk({tag, ".done_req_valid"}, 64'(mem_req_valid), 64'd0);
      if (i == out_lat) begin
        total++;
        assert (sb.size() > 0) else begin
          bad++;
          $error("FAIL %s.sb_empty: got 0 entries want 1", tag);
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk({tag, ".out_data"}, out_data, e.data);
`ifdef YSYX_25060170_LSU_MISALIGN_EN
          chk({tag, ".ls_except"}, 64'(ls_except), 64'(e.exc));
          chk({tag, ".ls_cause"},  64'(ls_cause),  64'(e.cause));
`endif
        end
      end
      // A new op offered during DONE must not be taken, even on the handshake cycle.
      in_valid = 1'b1; ls_ctl = 4'b0000; alu_res = 64'h0BAD_0BAD_0BAD_0BAD;
      out_ready = (i == out_lat);
      @(negedge clk);
    end
    out_ready = 1'b0; in_valid = 1'b0;
    chk({tag, ".post_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".post_in_ready"},  64'(in_ready),  64'd1);
`ifdef YSYX_25060170_LSU_MISALIGN_EN
    chk({tag, ".post_except"}, 64'(ls_except), 64'd0);
`endif
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; alu_res = '0; store_data = '0; ls_ctl = '0;
    out_ready = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst.in_ready",  64'(in_ready),      64'd1);
    chk("rst.out_valid", 64'(out_valid),     64'd0);
    chk("rst.out_data",  out_data,           64'd0);
    chk("rst.req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst.we",        64'(mem_we),        64'd0);
    chk("rst.addr",      64'(mem_addr),      64'd0);
    chk("rst.wdata",     mem_wdata,          64'd0);
    chk("rst.wstrb",     64'(mem_wstrb),     64'd0);
    chk("rst.size",      64'(mem_size),      64'd0);
`ifdef YSYX_25060170_LSU_MISALIGN_EN
    chk("rst.except",    64'(ls_except),     64'd0);
    chk("rst.cause",     64'(ls_cause),      64'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    chk("rst.req_low_after", 64'(mem_req_valid), 64'd0);

    //      tag      ctl      alu              store_data             rdata                 rq oq bus we strb   wdata                  sz  out_data
    run_op("lb",    4'b1001, 64'h8000_0003, 64'h0,                 64'h0000_0000_80FF_0000, 0, 0, 1, 0, 8'h00, 64'h0,                 3'd0, 64'hFFFF_FFFF_FFFF_FF80, 0, 0);
    run_op("sh",    4'b0010, 64'h8000_0006, 64'h0000_0000_0000_BEEF, 64'h0,                0, 0, 1, 1, 8'hC0, 64'hBEEF_0000_0000_0000, 3'd1, 64'h0, 0, 0);
    run_op("bp_sw", 4'b0100, 64'h8000_0010, 64'h1122_3344_5566_7788, 64'h0,                5, 3, 1, 1, 8'h0F, 64'h0000_0000_5566_7788, 3'd2, 64'h0, 0, 0);
    run_op("nonmem",4'b0000, 64'h0000_1234, 64'h0,                 64'h0,                   0, 0, 0, 0, 8'h00, 64'h0,                 3'd0, 64'h0000_1234, 0, 0);
    run_op("lh",    4'b1010, 64'h8000_0102, 64'h0,                 64'h0000_0000_F00D_0000, 1, 1, 1, 0, 8'h00, 64'h0,                 3'd1, 64'hFFFF_FFFF_FFFF_F00D, 0, 0);
    run_op("lhu",   4'b1110, 64'h8000_0102, 64'h0,                 64'h0000_0000_F00D_0000, 0, 0, 1, 0, 8'h00, 64'h0,                 3'd1, 64'h0000_0000_0000_F00D, 0, 0);
    run_op("lw",    4'b1011, 64'h8000_0204, 64'h0,                 64'h8765_4321_0000_0000, 0, 0, 1, 0, 8'h00, 64'h0,                 3'd2, 64'hFFFF_FFFF_8765_4321, 0, 0);
    run_op("lwu",   4'b1111, 64'h8000_0204, 64'h0,                 64'h8765_4321_0000_0000, 0, 0, 1, 0, 8'h00, 64'h0,                 3'd2, 64'h0000_0000_8765_4321, 0, 0);
    run_op("lbu",   4'b1101, 64'h8000_0305, 64'h0,                 64'h0000_9A00_0000_0000, 0, 0, 1, 0, 8'h00, 64'h0,                 3'd0, 64'h0000_0000_0000_009A, 0, 0);
    run_op("ld",    4'b1100, 64'h8000_0408, 64'h0,                 64'h0123_4567_89AB_CDEF, 0, 0, 1, 0, 8'h00, 64'h0,                 3'd3, 64'h0123_4567_89AB_CDEF, 0, 0);
    run_op("sb",    4'b0001, 64'h8000_0507, 64'h1234_5678_9ABC_FFAB, 64'h0,                0, 0, 1, 1, 8'h80, 64'hAB00_0000_0000_0000, 3'd0, 64'h0, 0, 0);
    run_op("sd",    4'b0101, 64'h8000_0608, 64'hDEAD_BEEF_CAFE_F00D, 64'h0,                0, 0, 1, 1, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 3'd3, 64'h0, 0, 0);
`ifdef YSYX_25060170_LSU_MISALIGN_EN
    run_op("mis_lw",4'b1011, 64'h8000_0002, 64'h0,                 64'h1111_2222_3333_4444, 0, 0, 0, 0, 8'h00, 64'h0,                 3'd2, 64'h0000_0000_8000_0002, 1, 4'd4);
    run_op("mis_sw",4'b0100, 64'h8000_0006, 64'h0000_0000_AABB_CCDD, 64'h0,                0, 1, 0, 0, 8'h00, 64'h0,                 3'd2, 64'h0000_0000_8000_0006, 1, 4'd6);
`else
    run_op("mis_lw",4'b1011, 64'h8000_0002, 64'h0,                 64'h1111_2222_3333_4444, 0, 0, 1, 0, 8'h00, 64'h0,                 3'd2, 64'h0000_0000_2222_3333, 0, 0);
    run_op("mis_sw",4'b0100, 64'h8000_0006, 64'h0000_0000_AABB_CCDD, 64'h0,                0, 0, 1, 1, 8'hC0, 64'hCCDD_0000_0000_0000, 3'd2, 64'h0, 0, 0);
`endif

    // Reset while WAITing, then a late response must be dropped.
    @(negedge clk);
    in_valid = 1'b1; ls_ctl = 4'b1011; alu_res = 64'h8000_0020;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rstwait.req_valid", 64'(mem_req_valid), 64'd1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("rstwait.in_wait", 64'(mem_req_valid), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstwait.in_ready",  64'(in_ready),  64'd1);
    chk("rstwait.out_valid", 64'(out_valid), 64'd0);
    mem_rsp_valid = 1'b1; mem_rdata = 64'h7777_7777_7777_7777;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("rstwait.late_out_valid", 64'(out_valid),     64'd0);
    chk("rstwait.late_in_ready",  64'(in_ready),      64'd1);
    chk("rstwait.req_low_after",  64'(mem_req_valid), 64'd0);
    @(negedge clk);
    chk("rstwait.still_idle", 64'(out_valid), 64'd0);

    run_op("recover", 4'b0000, 64'h0000_0055, 64'h0, 64'h0, 0, 0, 0, 0, 8'h00, 64'h0, 3'd0, 64'h0000_0055, 0, 0);

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL sb_leftover: got %0d entries want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
